// File: rtl/fifo_test_pkg.sv
// fifo_test_pkg: shared state encoding and mode constants for the FIFO traffic checker
package fifo_test_pkg;
  typedef enum logic [2:0] {
    ST_WAIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_STREAM,
    ST_DONE
  } state_e;
  localparam int MODE_FILL_DRAIN = 0;
  localparam int MODE_STREAM     = 1;
  localparam int RD_LAT_FWFT     = 0;
  localparam int RD_LAT_STD      = 1;
endpackage

// File: rtl/fifo_data_checker.sv
// fifo_data_checker: read-side issue, expected-pattern compare and error/read accounting
//   clk_i, rst_ni         clock, async active-low reset
//   clear_i               accepted start: clears counters and reloads the expected value
//   read_phase_i          reads are allowed this cycle
//   fifo_empty_i          FIFO empty flag
//   fifo_dout_i           FIFO read data
//   fifo_rd_en_o          FIFO read enable
//   in_flight_o           a standard-latency read is waiting for its data
//   err_o                 sticky mismatch flag
//   err_cnt_o             saturating mismatch count
//   first_err_data_o      read data of the first mismatch
//   rd_cnt_o              words compared
module fifo_data_checker
  import fifo_test_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 256,
  parameter int SEED      = 1,
  parameter int RD_LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              read_phase_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_dout_i,
  output logic              fifo_rd_en_o,
  output logic              in_flight_o,
  output logic              err_o,
  output logic [15:0]       err_cnt_o,
  output logic [DATA_W-1:0] first_err_data_o,
  output logic [15:0]       rd_cnt_o
);
  logic [15:0]       issued_q, issued_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] exp_q, exp_d, fed_q, fed_d;
  logic              vld_q, vld_d, err_q, err_d, cmp, mis;

  always_comb begin
    fifo_rd_en_o = read_phase_i & ~fifo_empty_i & (issued_q < 16'(BURST_LEN));
    // FWFT data is valid alongside rd_en; standard data arrives one cycle later
    cmp          = (RD_LAT == RD_LAT_FWFT) ? fifo_rd_en_o : vld_q;
    mis          = cmp & (fifo_dout_i != exp_q);
    vld_d        = fifo_rd_en_o;
    issued_d     = clear_i ? '0 : issued_q + 16'(fifo_rd_en_o);
    rd_cnt_d     = clear_i ? '0 : rd_cnt_q + 16'(cmp);
    exp_d        = clear_i ? DATA_W'(SEED) : exp_q + DATA_W'(cmp);
    err_d        = ~clear_i & (err_q | mis);
    err_cnt_d    = clear_i ? '0 : err_cnt_q + 16'(mis & (err_cnt_q != 16'hFFFF));
    fed_d        = clear_i ? '0 : (mis & (err_cnt_q == '0)) ? fifo_dout_i : fed_q;
    in_flight_o  = (RD_LAT == RD_LAT_STD) & vld_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      issued_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
      exp_q     <= DATA_W'(SEED);
      fed_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      issued_q  <= issued_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      exp_q     <= exp_d;
      fed_q     <= fed_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end

  assign err_o            = err_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_data_o = fed_q;
  assign rd_cnt_o         = rd_cnt_q;
endmodule

// File: rtl/fifo_traffic_checker.sv
// fifo_traffic_checker: writes an incrementing pattern into a FIFO and checks it on read-back
//   sys_clk, rst_n        clock, async active-low reset
//   start                 one-cycle run request, honoured only when idle
//   fifo_din/wr_en/full   FIFO write port
//   fifo_dout/rd_en/empty FIFO read port
//   busy, done            run in progress / one-cycle completion pulse
//   err, err_cnt          sticky mismatch flag and saturating mismatch count
//   first_err_data        data read at the first mismatch of the run
//   rd_cnt                words checked this run
module fifo_traffic_checker
  import fifo_test_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 256,
  parameter int SEED      = 1,
  parameter int WAIT_CYC  = 80,
  parameter int RD_LAT    = 1,
  parameter int MODE      = 0
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       err_cnt,
  output logic [DATA_W-1:0] first_err_data,
  output logic [15:0]       rd_cnt
);
  localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              accept, write_phase, read_phase, in_flight;

  always_comb begin
    accept      = (state_q == ST_IDLE) & start;
    write_phase = (state_q == ST_WRITE) | (state_q == ST_STREAM);
    read_phase  = (state_q == ST_READ) | (state_q == ST_STREAM);
    fifo_wr_en  = write_phase & ~fifo_full & (wr_cnt_q < 16'(BURST_LEN));
    din_d       = accept ? DATA_W'(SEED) : din_q + DATA_W'(fifo_wr_en);
    wr_cnt_d    = accept ? '0 : wr_cnt_q + 16'(fifo_wr_en);
    busy        = write_phase | read_phase;
    done        = state_q == ST_DONE;
    wait_d      = wait_q;
    state_d     = state_q;
    case (state_q)
      ST_WAIT: begin
        wait_d  = wait_q + WAIT_W'(1);
        state_d = (wait_q == WAIT_W'(WAIT_CYC - 1)) ? ST_IDLE : ST_WAIT;
      end
      ST_IDLE:   state_d = !start ? ST_IDLE : (MODE == MODE_STREAM) ? ST_STREAM : ST_WRITE;
      ST_WRITE:  state_d = (wr_cnt_q == 16'(BURST_LEN)) ? ST_READ : ST_WRITE;
      // completion waits for any standard-latency compare still pending
      ST_READ,
      ST_STREAM: state_d = ((rd_cnt == 16'(BURST_LEN)) & ~in_flight) ? ST_DONE : state_q;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_WAIT;
      wait_q   <= '0;
      din_q    <= DATA_W'(SEED);
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      din_q    <= din_d;
      wr_cnt_q <= wr_cnt_d;
    end

  assign fifo_din = din_q;

  fifo_data_checker #(
    .DATA_W   (DATA_W),
    .BURST_LEN(BURST_LEN),
    .SEED     (SEED),
    .RD_LAT   (RD_LAT)
  ) u_chk (
    .clk_i           (sys_clk),
    .rst_ni          (rst_n),
    .clear_i         (accept),
    .read_phase_i    (read_phase),
    .fifo_empty_i    (fifo_empty),
    .fifo_dout_i     (fifo_dout),
    .fifo_rd_en_o    (fifo_rd_en),
    .in_flight_o     (in_flight),
    .err_o           (err),
    .err_cnt_o       (err_cnt),
    .first_err_data_o(first_err_data),
    .rd_cnt_o        (rd_cnt)
  );
endmodule
